// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared FSM states, op encodings and decoded-line indices for the serial ALU
package alu_serial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Op encodings as {m, s}; the A and ~A functions ignore m, so they are listed with m=0
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_IMP  = 3'b111;

    // Positions of each function within the 6-line decoded vector
    localparam int L_A    = 5;
    localparam int L_NA   = 4;
    localparam int L_XOR  = 3;
    localparam int L_XNOR = 2;
    localparam int L_OR   = 1;
    localparam int L_IMP  = 0;

endpackage

// File: rtl/alu_bit_fn.sv
// alu_bit_fn: one-bit ALU slice producing a one-hot-or-zero 6-line vector and its OR
module alu_bit_fn
    import alu_serial_pkg::*;
(
    input  logic       m,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] s,
    output logic [5:0] lines,
    output logic       y
);

    logic [2:0] op;

    assign op = {m, s};

    // Decode each function line; at most one is enabled for any (m, s)
    always_comb begin
        lines         = '0;
        lines[L_A]    = (s == OP_PASS[1:0]) & a;
        lines[L_NA]   = (s == OP_NOT[1:0]) & ~a;
        lines[L_XOR]  = (op == OP_XOR) & (a ^ b);
        lines[L_XNOR] = (op == OP_XNOR) & ~(a ^ b);
        lines[L_OR]   = (op == OP_OR) & (a | b);
        lines[L_IMP]  = (op == OP_IMP) & (~a | b);
        y             = |lines;
    end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: LSB-first bit-serial WIDTH-bit ALU around alu_bit_fn; ALU_SERIAL_ZFLAG_EN adds a zero flag
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             m,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             valid,
`ifdef ALU_SERIAL_ZFLAG_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, next;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic [CW-1:0]    cnt;
    logic             m_r;
    logic [1:0]       s_r;
    logic [5:0]       lines;
    logic             fbit;

    alu_bit_fn u_fn (
        .m     (m_r),
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .s     (s_r),
        .lines (lines),
        .y     (fbit)
    );

    assign ready = (state == IDLE);
    assign busy  = !ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next-state: accept in IDLE, leave SHIFT after the last bit, DONE lasts one cycle
    always_comb begin
        next = (state == IDLE)  ? (start ? SHIFT : IDLE) :
               (state == SHIFT) ? ((cnt == LAST) ? DONE : SHIFT) : IDLE;
    end

    // Operand capture, serial shifting, result assembly and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            m_r    <= 1'b0;
            s_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            result <= '0;
`ifdef ALU_SERIAL_ZFLAG_EN
            zero   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            if (state == IDLE && start) begin
                a_sh <= a;
                b_sh <= b;
                m_r  <= m;
                s_r  <= s;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                acc  <= {fbit, acc[WIDTH-1:1]};
                cnt  <= (cnt == LAST) ? cnt : cnt + CW'(1);
            end else if (state == DONE) begin
                result <= acc;
                valid  <= 1'b1;
`ifdef ALU_SERIAL_ZFLAG_EN
                zero   <= (acc == '0);
`endif
            end
        end
    end

    // The decode must never enable two function lines at once
    always_ff @(posedge clk) begin
        if (rst_n && state == SHIFT) assert ($onehot0(lines));
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed self-checking bench for alu_serial_seq (WIDTH=8), covers ALU_SERIAL_ZFLAG_EN when defined
module tb_alu_serial_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       m = 1'b0;
    logic [1:0] s = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       ready, busy, valid;
    logic [7:0] result;
`ifdef ALU_SERIAL_ZFLAG_EN
    logic       zero;
`endif

    int errors = 0;
    int checks = 0;

    alu_serial_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .m      (m),
        .s      (s),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .valid  (valid),
`ifdef ALU_SERIAL_ZFLAG_EN
        .zero   (zero),
`endif
        .result (result)
    );

    always #5 clk = ~clk;

    // Issues one op from a negedge; lat = clock edges after the accepting edge until valid is seen
    task automatic do_op(input logic om, input logic [1:0] os, input logic [7:0] oa, input logic [7:0] ob,
                         output logic [7:0] res, output int lat, output logic v_next);
        @(negedge clk);
        start = 1'b1; m = om; s = os; a = oa; b = ob;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        @(negedge clk);
        v_next = valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    endtask

    task automatic test_ops();
        logic [1:0] vs [7]  = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00};
        logic       vm [7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] va [7]  = '{8'hA5, 8'hA5, 8'h30, 8'hF0, 8'h0F, 8'h0F, 8'h5A};
        logic [7:0] vb [7]  = '{8'h0F, 8'h0F, 8'h03, 8'h30, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] exp [7] = '{8'hAA, 8'h55, 8'h33, 8'h3F, 8'hF0, 8'hF0, 8'h5A};
        logic [7:0] res;
        int lat;
        logic vn;
        for (int i = 0; i < 7; i++) begin
            do_op(vm[i], vs[i], va[i], vb[i], res, lat, vn);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL op%0d_result got=%h exp=%h", i, res, exp[i]); end
            checks++; if (lat !== 9) begin errors++; $display("FAIL op%0d_latency got=%0d exp=9", i, lat); end
            checks++; if (vn !== 1'b0) begin errors++; $display("FAIL op%0d_valid_width got=%b exp=0", i, vn); end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int v1 = -1;
        int v2 = -1;
        logic [7:0] r1 = 8'h00;
        logic [7:0] r2 = 8'h00;
        logic busy_mid = 1'b0;
        @(negedge clk);
        start = 1'b1; m = 1'b0; s = 2'b10; a = 8'hA5; b = 8'h0F;
        @(negedge clk);
        while (v2 < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) begin m = 1'b1; s = 2'b10; a = 8'h30; b = 8'h03; end
            if (n == 5) busy_mid = busy;
            if (valid && v1 < 0) begin v1 = n; r1 = result; end
            else if (valid && v1 >= 0) begin v2 = n; r2 = result; end
        end
        start = 1'b0;
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy_mid); end
        checks++; if (v1 !== 9) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=9", v1); end
        checks++; if (r1 !== 8'hAA) begin errors++; $display("FAIL b2b_first_result got=%h exp=aa", r1); end
        checks++; if (v2 - v1 !== 10) begin errors++; $display("FAIL b2b_period got=%0d exp=10", v2 - v1); end
        checks++; if (r2 !== 8'h33) begin errors++; $display("FAIL b2b_second_result got=%h exp=33", r2); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [7:0] res;
        int lat;
        logic vn;
        logic saw_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; m = 1'b0; s = 2'b10; a = 8'hA5; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL midrst_result got=%h exp=00", result); end
        for (int i = 0; i < 15; i++) begin
            if (valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid got=%b exp=0", saw_valid); end
        do_op(1'b1, 2'b11, 8'hF0, 8'h30, res, lat, vn);
        checks++; if (res !== 8'h3F) begin errors++; $display("FAIL midrst_next_result got=%h exp=3f", res); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=9", lat); end
    endtask

`ifdef ALU_SERIAL_ZFLAG_EN
    task automatic test_zflag();
        logic [7:0] res;
        int lat;
        logic vn;
        do_op(1'b0, 2'b00, 8'h00, 8'h00, res, lat, vn);
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL zf_result got=%h exp=00", res); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL zf_set got=%b exp=1", zero); end
        do_op(1'b0, 2'b00, 8'h01, 8'h00, res, lat, vn);
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL zf_clear got=%b exp=0", zero); end
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_mid_reset();
`ifdef ALU_SERIAL_ZFLAG_EN
        test_zflag();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
